// File: rtl/seg7_capture_if.sv
// Bus bundle for seg7_capture: capture request, the eight raw display
// segment buses, and the registered capture result.
interface seg7_capture_if;
    logic        start;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
    logic [6:0]  hex4;
    logic [6:0]  hex5;
    logic [6:0]  hex6;
    logic [6:0]  hex7;
    logic        busy;
    logic        valid;
    logic [31:0] value;
    logic [7:0]  bad_mask;
    logic        timeout;

    modport master (
        output start, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7,
        input  busy, valid, value, bad_mask, timeout
    );

    modport slave (
        input  start, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7,
        output busy, valid, value, bad_mask, timeout
    );
endinterface

// File: rtl/seg7_capture.sv
// Seven-segment read-back decoder: snapshots HEX0..HEX7, waits for the
// pattern to hold for STABLE_CYCLES, then decodes one digit per cycle into
// a 32-bit word with per-digit invalid-pattern flags.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic          clk,
    input  logic          rst,
    seg7_capture_if.slave bus
);
    localparam int unsigned    TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [7:0]     SC_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0]  TC_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DECODE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0][6:0]     snap_q, snap_d;
    logic [7:0]          scnt_q, scnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0][3:0]     value_q, value_d;
    logic [7:0]          bad_mask_q, bad_mask_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;

    logic [7:0][6:0]     live;
    logic [4:0]          dec;

    assign live = {bus.hex7, bus.hex6, bus.hex5, bus.hex4,
                   bus.hex3, bus.hex2, bus.hex1, bus.hex0};

    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.value    = value_q;
    assign bus.bad_mask = bad_mask_q;
    assign bus.timeout  = timeout_q;

    // Active-low gfedcba pattern to {bad, nibble}; unknown patterns flag bad.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0011000: r = 5'h09;
            7'b0001000: r = 5'h0A;
            7'b0000011: r = 5'h0B;
            7'b1000110: r = 5'h0C;
            7'b0100001: r = 5'h0D;
            7'b0000110: r = 5'h0E;
            7'b0001110: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    // Next-state and datapath; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        scnt_d     = scnt_q;
        tcnt_d     = tcnt_q;
        idx_d      = idx_q;
        value_d    = value_q;
        bad_mask_d = bad_mask_q;
        timeout_d  = timeout_q;
        dec        = seg_decode(snap_q[idx_q]);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    snap_d     = live;
                    scnt_d     = '0;
                    tcnt_d     = '0;
                    value_d    = '0;
                    bad_mask_d = '0;
                    timeout_d  = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + 1'b1;
                if (live == snap_q) begin
                    scnt_d = scnt_q + 8'd1;
                    if (scnt_q == SC_LAST) begin
                        state_d = S_DECODE;
                        idx_d   = '0;
                    end
                end else begin
                    snap_d = live;
                    scnt_d = '0;
                end
                // Stability wins if it lands on the same edge as the timeout.
                if (state_d != S_DECODE && tcnt_q == TC_LAST) begin
                    state_d    = S_DONE;
                    timeout_d  = 1'b1;
                    value_d    = '0;
                    bad_mask_d = '1;
                end
            end
            S_DECODE: begin
                value_d[idx_q]    = dec[3:0];
                bad_mask_d[idx_q] = dec[4];
                idx_d             = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d == S_WAIT) || (state_d == S_DECODE);
        valid_d = (state_d == S_DONE);
    end

    // State and output registers; reset clears everything including any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            snap_q     <= '0;
            scnt_q     <= '0;
            tcnt_q     <= '0;
            idx_q      <= '0;
            value_q    <= '0;
            bad_mask_q <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            scnt_q     <= scnt_d;
            tcnt_q     <= tcnt_d;
            idx_q      <= idx_d;
            value_q    <= value_d;
            bad_mask_q <= bad_mask_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end
endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: stimulus pushes expected results,
// a negedge monitor pops and compares whenever valid is presented.
module tb_seg7_capture;
    localparam int unsigned STABLE = 4;
    localparam int unsigned TMO    = 1024;

    logic clk = 1'b0;
    logic rst;

    seg7_capture_if bus ();

    seg7_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  mask;
        logic        to;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    int unsigned cyc = 0;
    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic prev_valid = 1'b0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic set_digits(input logic [31:0] nibs);
        bus.hex0 = seg_tab[nibs[3:0]];
        bus.hex1 = seg_tab[nibs[7:4]];
        bus.hex2 = seg_tab[nibs[11:8]];
        bus.hex3 = seg_tab[nibs[15:12]];
        bus.hex4 = seg_tab[nibs[19:16]];
        bus.hex5 = seg_tab[nibs[23:20]];
        bus.hex6 = seg_tab[nibs[27:24]];
        bus.hex7 = seg_tab[nibs[31:28]];
    endtask

    // Pulse start across one edge and queue the result expected lat cycles later.
    task automatic do_start(input logic [31:0] v, input logic [7:0] m, input logic to,
                            input int unsigned lat);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.value = v;
        e.mask  = m;
        e.to    = to;
        e.cyc   = cyc + lat;
        sb.push_back(e);
        check("busy_rise", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every valid cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.valid) begin
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            check("busy_at_valid", {31'd0, bus.busy}, 32'd0);
            if (sb.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_valid: got valid=1 expected no result (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("value", bus.value, e.value);
                check("bad_mask", {24'd0, bus.bad_mask}, {24'd0, e.mask});
                check("timeout", {31'd0, bus.timeout}, {31'd0, e.to});
                check("latency", cyc, e.cyc);
            end
        end
        prev_valid = bus.valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 1'b0;
        set_digits(32'h0);
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_value", bus.value, 32'd0);
        check("rst_mask", {24'd0, bus.bad_mask}, 32'd0);
        check("rst_timeout", {31'd0, bus.timeout}, 32'd0);
        rst = 1'b0;

        // All zeros.
        set_digits(32'h0000_0000);
        do_start(32'h0000_0000, 8'h00, 1'b0, 12);
        wait_drain(30);

        // 1..8 across hex7..hex0.
        set_digits(32'h1234_5678);
        do_start(32'h1234_5678, 8'h00, 1'b0, 12);
        wait_drain(30);

        // F, d, blank digit.
        set_digits(32'h0);
        bus.hex0 = 7'b0001110;
        bus.hex1 = 7'b0100001;
        bus.hex3 = 7'b1111111;
        do_start(32'h0000_00DF, 8'h08, 1'b0, 12);
        wait_drain(30);

        // hex0 changes after the first WAIT edge: stability restarts.
        set_digits(32'h0);
        do_start(32'h0000_0007, 8'h00, 1'b0, 14);
        @(negedge clk);
        @(negedge clk);
        bus.hex0 = seg_tab[7];
        wait_drain(30);

        // Toggling input never stabilises: timeout.
        set_digits(32'h0);
        do_start(32'h0000_0000, 8'hFF, 1'b1, TMO);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (i % 2 == 0) bus.hex2 = (bus.hex2 == seg_tab[0]) ? seg_tab[1] : seg_tab[0];
        end
        wait_drain(10);
        check("timeout_hold", {31'd0, bus.timeout}, 32'd1);

        // Steady capture after timeout clears the flag.
        set_digits(32'hABCD_EF09);
        do_start(32'hABCD_EF09, 8'h00, 1'b0, 12);
        wait_drain(30);

        // Reset in the middle of DECODE discards the partial result.
        set_digits(32'h1111_1111);
        do_start(32'h1111_1111, 8'h00, 1'b0, 12);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
        check("mid_rst_value", bus.value, 32'd0);
        check("mid_rst_mask", {24'd0, bus.bad_mask}, 32'd0);
        check("mid_rst_timeout", {31'd0, bus.timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_digits(32'h8765_4321);
        do_start(32'h8765_4321, 8'h00, 1'b0, 12);
        wait_drain(30);

        // start during WAIT and during DONE is ignored.
        set_digits(32'h0F0F_0F0F);
        do_start(32'h0F0F_0F0F, 8'h00, 1'b0, 12);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", {31'd0, bus.valid}, 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("no_requeue_busy", {31'd0, bus.busy}, 32'd0);
        check("no_extra", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/seg7_capture.md
# seg7_capture

Read-back decoder for the board's eight active-low seven-segment displays. It samples HEX0..HEX7, waits until the displayed pattern has held still for a programmable number of cycles, then decodes one digit per cycle back to its 4-bit hex value. The result is assembled into a 32-bit word, with per-digit error flags. It sits beside the hex display drivers as a self-check and debug path, so the bench and CPU can confirm what the displays actually show.

## Interface
- STABLE_CYCLES, 4: consecutive matching cycles required before decoding; legal range 1..255.
- TIMEOUT, 1024: maximum cycles spent waiting for stability before aborting; must exceed STABLE_CYCLES.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a capture; sampled only in IDLE.
- hex0..hex7  in  7 each  display segments {g,f,e,d,c,b,a}, active-low; hexN drives digit N.
- busy  out  1  high in WAIT and DECODE.
- valid  out  1  one-cycle pulse when a result is ready; high only in DONE.
- value  out  32  decoded word; value[4N+3:4N] comes from hexN.
- bad_mask  out  8  bit N set when hexN held a non-hex pattern.
- timeout  out  1  last capture aborted without stabilising.

## Operation
- States are IDLE, WAIT, DECODE and DONE. Reset puts the block in IDLE, and every output and internal register is 0.
- IDLE:
  - An edge with start=1 loads snap<=all eight hex inputs, scnt<=0, tcnt<=0, and moves to WAIT.
  - That same edge clears value, bad_mask and timeout.
- WAIT, on each edge:
  - tcnt increments.
  - If all 56 input bits equal snap, scnt increments. Otherwise snap reloads from the inputs and scnt<=0.
  - If a match occurs with scnt==STABLE_CYCLES-1, go to DECODE with idx<=0. This takes priority over timeout.
  - Otherwise, if tcnt==TIMEOUT-1, go to DONE with timeout<=1, value<=0 and bad_mask<=8'hFF.
- DECODE:
  - Each edge decodes snap digit idx (not the live inputs) into value[4idx+3:4idx] and bad_mask[idx], then idx increments.
  - After idx 7, go to DONE.
- Decode table (active-low, gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0011000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - Any other pattern decodes to nibble 0 and sets the bad bit.
- DONE lasts exactly one cycle with valid=1, then returns to IDLE.
- value, bad_mask and timeout hold their last result until the next accepted start.
- start in WAIT, DECODE or DONE is ignored and does not queue.
- Input changes during DECODE do not affect the result.
- rst asserted in any state returns the block to IDLE immediately and clears all outputs. A partially assembled value is discarded.

## Timing
- Latency with stable inputs: start accepted at edge E, WAIT spans edges E+1..E+STABLE_CYCLES, DECODE spans the next 8 edges.
- valid is therefore high during the cycle after edge E+STABLE_CYCLES+8. With defaults, valid rises 12 cycles after the start edge.
- busy rises the cycle after the start edge and falls when valid rises.
- Each input change during WAIT restarts the stability count. Minimum total latency is STABLE_CYCLES+8 cycles.
- Timeout: valid and timeout rise the cycle after edge E+TIMEOUT.
- start high in the DONE cycle is ignored. start held high continuously re-captures starting from the first IDLE cycle.
- Outputs are all registered. No combinational path runs from the inputs to the outputs.

## Test plan
- Reset, then all inputs 1000000 and a 1-cycle start: valid rises 12 cycles later, value=32'h0000_0000, bad_mask=0, timeout=0; valid lasts one cycle and busy drops with it.
- Drive hex7..hex0 = 1,2,3,4,5,6,7,8 and pulse start: value=32'h1234_5678, bad_mask=0.
- Drive hex0=0001110 (F), hex1=0100001 (d), hex3=1111111 (blank), the rest 0 and pulse start: value=32'h0000_00DF, bad_mask=8'h08.
- Start with the default parameters, then toggle hex2 every 2 cycles for 1100 cycles: timeout=1 and valid both rise at start edge +1024; value=0, bad_mask=8'hFF. A second start with steady inputs clears timeout.
- Start with steady inputs, then change hex0 on cycle 2 of WAIT: valid is delayed by the restart to 14 cycles after the start edge, and value reflects the new hex0.
- Assert rst during DECODE: outputs are 0 immediately and busy=0; a following start completes normally. A start pulsed while busy is ignored, with exactly one valid pulse per accepted start.
